// File: rtl/dual_writeback_arbiter_pkg.sv
// Shared core constants and helpers for the dual write-back arbiter.
package dual_writeback_arbiter_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned NUM_REGS      = 32;
  localparam int unsigned DEFAULT_DEPTH = 4;

  // Source feeding a register-file write port in a given cycle.
  typedef enum logic [1:0] {
    SrcNone,
    SrcAlu,
    SrcBuf,
    SrcLl
  } wb_src_e;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] oh;
    oh     = '0;
    oh[rd] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Long-latency result buffer: 1 write, 2 head reads, per-entry live bits and
// an rd-match kill so younger ALU writes can retire stale buffered results.
module wb_fifo #(
  parameter int unsigned XLEN  = dual_writeback_arbiter_pkg::XLEN,
  parameter int unsigned DEPTH = dual_writeback_arbiter_pkg::DEFAULT_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [4:0]      push_rd,
  input  logic [XLEN-1:0] push_data,
  input  logic [1:0]      pop_cnt,
  input  logic            kill0_en,
  input  logic [4:0]      kill0_rd,
  input  logic            kill1_en,
  input  logic [4:0]      kill1_rd,
  output logic            head0_valid,
  output logic            head0_live,
  output logic [4:0]      head0_rd,
  output logic [XLEN-1:0] head0_data,
  output logic            head1_valid,
  output logic            head1_live,
  output logic [4:0]      head1_rd,
  output logic [XLEN-1:0] head1_data,
  output logic            full,
  output logic            empty,
  output logic [31:0]     pending_mask
);
  import dual_writeback_arbiter_pkg::*;

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0]       rptr_q, rptr_d, wptr_q, wptr_d, rptr1;
  logic [CntW-1:0]       count_q, count_d;
  logic [DEPTH-1:0]      live_q, live_d, kill_hit;
  logic [REG_ADDR_W-1:0] rd_q [DEPTH];
  logic [REG_ADDR_W-1:0] rd_d [DEPTH];
  logic [XLEN-1:0]       data_q [DEPTH];
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  assign rptr1        = rptr_q + 1'b1;
  assign full         = (count_q == CntW'(DEPTH));
  assign empty        = (count_q == '0);
  assign pending_mask = pending_q;

  // Per-entry kill match against the ALU lanes writing this cycle.
  always_comb begin
    kill_hit = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      kill_hit[i] = (kill0_en && (rd_q[i] == kill0_rd)) || (kill1_en && (rd_q[i] == kill1_rd));
    end
  end

  // Head views; live already excludes entries killed in this same cycle.
  always_comb begin
    head0_valid = !empty;
    head1_valid = (count_q > CntW'(1));
    head0_live  = head0_valid && live_q[rptr_q] && !kill_hit[rptr_q];
    head1_live  = head1_valid && live_q[rptr1] && !kill_hit[rptr1];
    head0_rd    = rd_q[rptr_q];
    head1_rd    = rd_q[rptr1];
    head0_data  = data_q[rptr_q];
    head1_data  = data_q[rptr1];
  end

  // Next-state: kill, pop, push, then rebuild the pending mask from the result.
  always_comb begin
    live_d = live_q & ~kill_hit;
    rd_d   = rd_q;
    rptr_d = rptr_q + PtrW'(pop_cnt);
    wptr_d = wptr_q;
    if (pop_cnt != 2'd0) live_d[rptr_q] = 1'b0;
    if (pop_cnt == 2'd2) live_d[rptr1] = 1'b0;
    if (push) begin
      live_d[wptr_q] = 1'b1;
      rd_d[wptr_q]   = push_rd;
      wptr_d         = wptr_q + 1'b1;
    end
    count_d   = count_q - CntW'(pop_cnt) + CntW'(push);
    pending_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_d[i]) pending_d = pending_d | rd_onehot(rd_d[i]);
    end
  end

  // Control state with asynchronous reset; in-flight results are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      live_q    <= '0;
      pending_q <= '0;
    end else begin
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      live_q    <= live_d;
      pending_q <= pending_d;
    end
  end

  // Payload storage needs no reset; live bits qualify every entry.
  always_ff @(posedge clk) begin
    rd_q <= rd_d;
    if (push) data_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/dual_writeback_arbiter.sv
// Merges two zero-latency ALU lanes and a buffered long-latency stream onto two
// register-file write ports, keeping younger ALU results authoritative.
module dual_writeback_arbiter #(
  parameter int unsigned XLEN  = dual_writeback_arbiter_pkg::XLEN,
  parameter int unsigned DEPTH = dual_writeback_arbiter_pkg::DEFAULT_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu0_valid,
  input  logic [4:0]      alu0_rd,
  input  logic [XLEN-1:0] alu0_data,
  input  logic            alu1_valid,
  input  logic [4:0]      alu1_rd,
  input  logic [XLEN-1:0] alu1_data,
  input  logic            ll_valid,
  input  logic [4:0]      ll_rd,
  input  logic [XLEN-1:0] ll_data,
  output logic            ll_ready,
  output logic            we1,
  output logic [4:0]      rd1,
  output logic [XLEN-1:0] wdata1,
  output logic            we2,
  output logic [4:0]      rd2,
  output logic [XLEN-1:0] wdata2,
  output logic [31:0]     pending_mask
);
  import dual_writeback_arbiter_pkg::*;

  logic            p1_alu, p2_alu, ll_kill, ll_take, bypass, push;
  logic [1:0]      n_free, pop_cnt;
  logic            head0_valid, head0_live, head1_valid, head1_live, head0_wr, head1_wr;
  logic [4:0]      head0_rd, head1_rd;
  logic [XLEN-1:0] head0_data, head1_data;
  logic            fifo_full, fifo_empty;
  wb_src_e         src1, src2;

  assign p1_alu   = alu0_valid && (alu0_rd != 5'd0);
  assign p2_alu   = alu1_valid && (alu1_rd != 5'd0);
  // A same-cycle ll result aimed at an ALU destination is already stale.
  assign ll_kill  = (p1_alu && (ll_rd == alu0_rd)) || (p2_alu && (ll_rd == alu1_rd));
  assign ll_ready = !reset && !fifo_full;
  assign ll_take  = ll_valid && ll_ready && (ll_rd != 5'd0) && !ll_kill;
  assign bypass   = ll_take && fifo_empty && (!p1_alu || !p2_alu);
  assign push     = ll_take && !bypass;

  // Drain slots = free ports, bounded by occupancy; dead heads still use a slot.
  always_comb begin
    n_free = {1'b0, !p1_alu} + {1'b0, !p2_alu};
    if (!head0_valid) begin
      pop_cnt = 2'd0;
    end else if (!head1_valid && (n_free == 2'd2)) begin
      pop_cnt = 2'd1;
    end else begin
      pop_cnt = n_free;
    end
    // Two drained entries with one rd: only the younger one may write.
    head0_wr = head0_live &&
               !((pop_cnt == 2'd2) && head1_live && (head1_rd == head0_rd));
    head1_wr = head1_live && (pop_cnt == 2'd2);
  end

  // Port source selection: ALU lane owns its port, then buffer head, then bypass.
  always_comb begin
    src1 = SrcNone;
    src2 = SrcNone;
    if (p1_alu)                 src1 = SrcAlu;
    else if (pop_cnt != 2'd0)   src1 = SrcBuf;
    else if (bypass)            src1 = SrcLl;
    if (p2_alu)                 src2 = SrcAlu;
    else if (pop_cnt != 2'd0)   src2 = SrcBuf;
    else if (bypass && p1_alu)  src2 = SrcLl;
  end

  // Write-port drive; port 2 takes head1 only when port 1 consumed head0.
  always_comb begin
    we1    = 1'b0;
    rd1    = '0;
    wdata1 = '0;
    we2    = 1'b0;
    rd2    = '0;
    wdata2 = '0;
    case (src1)
      SrcAlu: begin we1 = 1'b1;     rd1 = alu0_rd;  wdata1 = alu0_data;  end
      SrcBuf: begin we1 = head0_wr; rd1 = head0_rd; wdata1 = head0_data; end
      SrcLl:  begin we1 = 1'b1;     rd1 = ll_rd;    wdata1 = ll_data;    end
      default: ;
    endcase
    case (src2)
      SrcAlu: begin we2 = 1'b1; rd2 = alu1_rd; wdata2 = alu1_data; end
      SrcBuf: begin
        if (p1_alu) begin
          we2 = head0_wr; rd2 = head0_rd; wdata2 = head0_data;
        end else begin
          we2 = head1_wr; rd2 = head1_rd; wdata2 = head1_data;
        end
      end
      SrcLl:  begin we2 = 1'b1; rd2 = ll_rd; wdata2 = ll_data; end
      default: ;
    endcase
    if (reset) begin
      we1 = 1'b0;
      we2 = 1'b0;
    end
  end

  wb_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_rd      (ll_rd),
    .push_data    (ll_data),
    .pop_cnt      (pop_cnt),
    .kill0_en     (p1_alu),
    .kill0_rd     (alu0_rd),
    .kill1_en     (p2_alu),
    .kill1_rd     (alu1_rd),
    .head0_valid  (head0_valid),
    .head0_live   (head0_live),
    .head0_rd     (head0_rd),
    .head0_data   (head0_data),
    .head1_valid  (head1_valid),
    .head1_live   (head1_live),
    .head1_rd     (head1_rd),
    .head1_data   (head1_data),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .pending_mask (pending_mask)
  );

endmodule

// File: tb/tb_dual_writeback_arbiter.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_dual_writeback_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu0_valid, alu1_valid, ll_valid;
  logic [4:0]      alu0_rd, alu1_rd, ll_rd;
  logic [XLEN-1:0] alu0_data, alu1_data, ll_data;
  logic            ll_ready, we1, we2;
  logic [4:0]      rd1, rd2;
  logic [XLEN-1:0] wdata1, wdata2;
  logic [31:0]     pending_mask;

  always #5 clk = ~clk;

  dual_writeback_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu0_valid(alu0_valid), .alu0_rd(alu0_rd), .alu0_data(alu0_data),
    .alu1_valid(alu1_valid), .alu1_rd(alu1_rd), .alu1_data(alu1_data),
    .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
    .we1(we1), .rd1(rd1), .wdata1(wdata1),
    .we2(we2), .rd2(rd2), .wdata2(wdata2),
    .pending_mask(pending_mask)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ent_t;

  ent_t q[$];
  ent_t nq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  task automatic drive(input logic a0v, input logic [4:0] a0r, input logic [31:0] a0d,
                       input logic a1v, input logic [4:0] a1r, input logic [31:0] a1d,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    alu0_valid = a0v; alu0_rd = a0r; alu0_data = a0d;
    alu1_valid = a1v; alu1_rd = a1r; alu1_data = a1d;
    ll_valid   = lv;  ll_rd   = lr;  ll_data   = ld;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reference model: derive this cycle's writes and the next buffer contents.
  task automatic model_compare();
    bit          e_we1, e_we2, e_rdy, c1, c2, llk;
    logic [4:0]  e_rd1, e_rd2;
    logic [31:0] e_wd1, e_wd2, e_pm;
    int          ports[$];
    ent_t        d[$];
    int          k;
    e_we1 = 0; e_we2 = 0; e_rd1 = 0; e_rd2 = 0; e_wd1 = 0; e_wd2 = 0; e_rdy = 0;
    e_pm = 0;
    foreach (q[i]) if (q[i].live) e_pm[q[i].rd] = 1'b1;
    nq = {};
    if (reset) begin
      e_pm = 0;
    end else begin
      nq = q;
      c1 = alu0_valid && alu0_rd != 0;
      c2 = alu1_valid && alu1_rd != 0;
      foreach (nq[i])
        if ((c1 && nq[i].rd == alu0_rd) || (c2 && nq[i].rd == alu1_rd)) nq[i].live = 0;
      llk   = (c1 && ll_rd == alu0_rd) || (c2 && ll_rd == alu1_rd);
      e_rdy = q.size() < DEPTH;
      if (c1) begin e_we1 = 1; e_rd1 = alu0_rd; e_wd1 = alu0_data; end
      else ports.push_back(1);
      if (c2) begin e_we2 = 1; e_rd2 = alu1_rd; e_wd2 = alu1_data; end
      else ports.push_back(2);
      if (nq.size() == 0) begin
        if (ll_valid && ll_rd != 0 && !llk) begin
          if (ports.size() == 0) nq.push_back('{ll_rd, ll_data, 1'b1});
          else if (ports[0] == 1) begin e_we1 = 1; e_rd1 = ll_rd; e_wd1 = ll_data; end
          else begin e_we2 = 1; e_rd2 = ll_rd; e_wd2 = ll_data; end
        end
      end else begin
        k = (ports.size() < nq.size()) ? ports.size() : nq.size();
        for (int i = 0; i < k; i++) d.push_back(nq.pop_front());
        if (k == 2 && d[0].live && d[1].live && d[0].rd == d[1].rd) d[0].live = 0;
        for (int i = 0; i < k; i++) begin
          if (d[i].live) begin
            if (ports[i] == 1) begin e_we1 = 1; e_rd1 = d[i].rd; e_wd1 = d[i].data; end
            else begin e_we2 = 1; e_rd2 = d[i].rd; e_wd2 = d[i].data; end
          end
        end
        if (ll_valid && e_rdy && ll_rd != 0 && !llk) nq.push_back('{ll_rd, ll_data, 1'b1});
      end
    end
    chk("ll_ready", ll_ready, e_rdy);
    chk("pending_mask", pending_mask, e_pm);
    chk("we1", we1, e_we1);
    chk("we2", we2, e_we2);
    if (e_we1) begin chk("rd1", rd1, e_rd1); chk("wdata1", wdata1, e_wd1); end
    if (e_we2) begin chk("rd2", rd2, e_rd2); chk("wdata2", wdata2, e_wd2); end
  endtask

  task automatic settle();
    #1;
    model_compare();
  endtask

  task automatic tick();
    @(posedge clk);
    q = nq;
    @(negedge clk);
  endtask

  initial begin
    int ll_i;
    reset = 1'b1;
    idle();
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("rst_ready", ll_ready, 0);
      tick();
    end
    reset = 1'b0;
    settle();
    chk("ready_after_rst", ll_ready, 1);
    tick();

    // Empty-buffer bypass to port 1.
    drive(0, 0, 0, 0, 0, 0, 1, 5, 32'h1234);
    settle();
    chk("byp_we1", we1, 1); chk("byp_rd1", rd1, 5); chk("byp_wd1", wdata1, 32'h1234);
    chk("byp_we2", we2, 0);
    tick();
    idle(); settle();
    chk("byp_empty_pm", pending_mask, 0); chk("byp_empty_we1", we1, 0);
    tick();

    // Fill to full behind busy lanes, then drain two per cycle.
    ll_i = 1;
    for (int c = 0; c < 6; c++) begin
      drive(1, 20, c, 1, 21, c, 1, 5'(ll_i), 32'h100 + ll_i);
      settle();
      chk($sformatf("fill_ready_c%0d", c), ll_ready, c < 4);
      if (ll_ready) ll_i++;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 5, 32'h105);
    settle();
    chk("drain_a_rd1", rd1, 1); chk("drain_a_wd1", wdata1, 32'h101);
    chk("drain_a_rd2", rd2, 2); chk("drain_a_we2", we2, 1); chk("drain_a_rdy", ll_ready, 0);
    tick();
    settle();
    chk("drain_b_rd1", rd1, 3); chk("drain_b_rd2", rd2, 4); chk("drain_b_rdy", ll_ready, 1);
    tick();
    idle(); settle();
    chk("drain_c_we1", we1, 1); chk("drain_c_rd1", rd1, 5); chk("drain_c_wd1", wdata1, 32'h105);
    chk("drain_c_we2", we2, 0);
    tick();

    // Both lanes to the same rd.
    drive(1, 3, 32'hA, 1, 3, 32'hB, 0, 0, 0);
    settle();
    chk("same_we1", we1, 1); chk("same_we2", we2, 1); chk("same_rd1", rd1, 3);
    chk("same_rd2", rd2, 3); chk("same_wd1", wdata1, 32'hA); chk("same_wd2", wdata2, 32'hB);
    tick();
    idle(); settle(); chk("same_pm", pending_mask, 0); tick();

    // ll with rd 0 while lanes busy: accepted, dropped.
    drive(1, 20, 0, 1, 21, 0, 1, 0, 32'h55);
    settle(); chk("rd0_ready", ll_ready, 1); tick();
    idle(); settle();
    chk("rd0_we1", we1, 0); chk("rd0_we2", we2, 0); chk("rd0_pm", pending_mask, 0);
    tick();

    // Kill of a buffered rd 7 by a younger ALU write.
    drive(1, 20, 0, 1, 21, 0, 1, 7, 32'h77); settle(); tick();
    drive(1, 7, 32'h70, 1, 21, 0, 0, 0, 0); settle();
    chk("kill_pm_set", pending_mask, 32'h80); tick();
    drive(1, 22, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("kill_pm_clr", pending_mask, 0); chk("kill_pop_we2", we2, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 9, 32'h99); settle();
    chk("kill_empty_we1", we1, 1); chk("kill_empty_rd1", rd1, 9); tick();

    // Reset mid-drain with three entries left.
    for (int c = 0; c < 4; c++) begin
      drive(1, 20, 0, 1, 21, 0, 1, 5'(11 + c), 32'h200 + c); settle(); tick();
    end
    drive(1, 20, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("rstd_rd2_a", rd2, 11); tick();
    settle();
    chk("rstd_rd2_b", rd2, 12); chk("rstd_pm", pending_mask, 32'h7000);
    reset = 1'b1;
    settle();
    chk("rstd_we1", we1, 0); chk("rstd_we2", we2, 0); chk("rstd_pm0", pending_mask, 0);
    tick();
    reset = 1'b0;
    idle(); settle();
    chk("rstd_post_we1", we1, 0); chk("rstd_post_we2", we2, 0);
    chk("rstd_post_rdy", ll_ready, 1);
    tick();

    // Randomized traffic with small rd range to force collisions and kills.
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
      if (c % 50 < 8) begin
        alu0_valid = 1'b0;
        alu1_valid = $urandom_range(0, 1);
      end
      settle();
      tick();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dual_writeback_arbiter.md
DUAL_WRITEBACK_ARBITER -- requirements
Module: dual_writeback_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning long-latency buffer entries (power of 2, minimum 2).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-005 The block SHALL have ports alu0_valid/alu0_rd/alu0_data, input, 1/5/XLEN, meaning lane-0 ALU result; it is always accepted and has no ready.
REQ-006 The block SHALL have ports alu1_valid/alu1_rd/alu1_data, input, 1/5/XLEN, meaning lane-1 ALU result; it is always accepted and has no ready.
REQ-007 The block SHALL have ports ll_valid/ll_rd/ll_data, input, 1/5/XLEN, meaning long-latency (mul/div/load/FFT) result.
REQ-008 The block SHALL have port ll_ready, output, 1, meaning a long-latency result is accepted this cycle.
REQ-009 The block SHALL have ports we1/rd1/wdata1 and we2/rd2/wdata2, output, 1/5/XLEN each, meaning the register-file write ports; port 1 has priority on an equal rd.
REQ-010 The block SHALL have port pending_mask, output, 32, meaning bit r is set while a live buffered result targets x[r].

Function
REQ-011 Lane 0 SHALL drive port 1 and lane 1 SHALL drive port 2 combinationally, with zero latency, whenever the lane is valid and rd != 0.
REQ-012 Results with rd == 0 on any channel SHALL be accepted and discarded, never written or buffered.
REQ-013 A port not claimed by its ALU lane SHALL be free; free ports SHALL be filled from the buffer head in order: oldest entry to port 1 if free, next to port 2.
REQ-014 The block SHALL drain at most two entries per cycle.
REQ-015 When the buffer is empty, ll_valid is high, rd != 0 and a port is free, the ll result SHALL bypass to the lowest free port in the same cycle without being enqueued.
REQ-016 Otherwise ll_valid && ll_ready SHALL enqueue the result.
REQ-017 ll_ready SHALL equal not-full, evaluated from the registered count; enqueue and dequeue in the same cycle SHALL be legal.
REQ-018 ALU results are always younger than any buffered ll result. A valid ALU lane with rd == R SHALL therefore kill every live buffered entry with rd R, plus a same-cycle ll result with rd R, which is accepted but not written.
REQ-019 A killed entry at the head SHALL pop without asserting a write enable, consuming one drain slot.
REQ-020 Buffer occupancy SHALL use wrap-around read/write pointers modulo DEPTH with a count of 0..DEPTH; full is count == DEPTH and empty is count == 0.
REQ-021 pending_mask SHALL be the registered OR of onehot(rd) over live entries, updated the cycle after enqueue, drain or kill.
REQ-022 The block SHALL never assert we1 and we2 with equal rd unless both are ALU lanes.

Reset
REQ-023 While reset is high, pointers, count and all live bits SHALL clear asynchronously.
REQ-024 While reset is high, we1, we2, ll_ready and pending_mask SHALL be 0.
REQ-025 Buffered results in flight at reset SHALL be lost.
REQ-026 ll_ready SHALL rise in the first cycle after reset deasserts.

Structure
REQ-027 XLEN, REG_ADDR_W = 5 and default DEPTH SHALL live in the shared core package.
REQ-028 The buffer SHALL be a sub-module wb_fifo providing 2-read/1-write ports, per-entry live bits and an rd-match kill input.
REQ-029 Port-selection logic SHALL be in the top level.

Verification
REQ-030 Both lanes idle, ll_valid with rd = 5, data = 0x1234 and buffer empty -> same cycle we1 = 1, rd1 = 5, wdata1 = 0x1234, and the buffer stays empty.
REQ-031 Both lanes busy for 6 cycles while ll presents 5 results -> 4 enqueued, ll_ready = 0 on the fifth, then both lanes idle -> 2 entries drained per cycle in order over 2 cycles and the fifth is accepted.
REQ-032 Buffer holds rd = 7 live, then alu0 writes rd = 7 -> pending_mask[7] clears next cycle, and the entry later pops with we low.
REQ-033 alu0 and alu1 both rd = 3 with data 0xA / 0xB -> we1 = we2 = 1, rd1 = rd2 = 3, and the buffer is untouched.
REQ-034 Reset asserted mid-drain with 3 entries buffered -> we1/we2/pending_mask = 0 immediately, and count = 0 after release.
REQ-035 ll result with rd = 0 while lanes are busy -> ll_ready = 1 and nothing is enqueued.
